// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizes, state enums and bit-reverse helper for the FFT output reorder
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_W     = 16;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_e;

  // Reverse the low 'bits' bits of v; bits above that come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r[5'(bits - 1 - i)] = v[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - one ping-pong bank: dual-half write, natural-order read
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [$clog2(N)-2:0]   wr_addr,
  input  logic [2*W-1:0]         wr_lo,
  input  logic [2*W-1:0]         wr_hi,
  input  logic [$clog2(N)-1:0]   rd_addr,
  output logic [2*W-1:0]         rd_data
);

  localparam int AW   = $clog2(N);
  localparam int HALF = N / 2;

  logic [2*W-1:0] lo_mem [HALF];
  logic [2*W-1:0] hi_mem [HALF];

  // A pair always lands at the same offset in both halves, so one address serves both.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lo_mem[wr_addr] <= wr_lo;
      hi_mem[wr_addr] <= wr_hi;
    end
  end

  // The top bin bit picks the half, the rest is the offset inside it.
  always_comb begin
    rd_data = rd_addr[AW-1] ? hi_mem[rd_addr[AW-2:0]] : lo_mem[rd_addr[AW-2:0]];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - bit-reversed FFT pair stream to natural-order bin stream
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_start,
  input  logic [W-1:0]         in_re0,
  input  logic [W-1:0]         in_im0,
  input  logic [W-1:0]         in_re1,
  input  logic [W-1:0]         in_im1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_re,
  output logic [W-1:0]         out_im,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 ovf,
  output logic                 frm_err
);

  localparam int AW = $clog2(N);
  localparam int PW = AW - 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(N / 2 - 1);
  localparam logic [AW-1:0] LAST_BIN  = AW'(N - 1);

  // write side
  wr_state_e     wst_q, wst_d;
  logic          wr_bank_q, wr_bank_d;
  logic [PW-1:0] pair_q, pair_d;
  logic          ovf_q, ovf_d;
  logic          frm_err_q, frm_err_d;
  logic          wr_en;
  logic          wr_done;
  logic [PW-1:0] wr_pair;
  logic [31:0]   b0_full;
  logic [PW-1:0] wr_addr;
  logic          unused_b0;

  // shared bank state
  logic [1:0]    full_q, full_d;

  // read side
  rd_state_e     rst_q, rst_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [W-1:0]  out_re_q, out_re_d;
  logic [W-1:0]  out_im_q, out_im_d;
  logic          rd_done;
  logic          rd_sel;
  logic          load;
  logic          other_bank;
  logic [AW-1:0] rd_addr;
  logic [2*W-1:0] rd_data0, rd_data1, rd_word;

  // Pair k holds bins bitrev(2k) and bitrev(2k)+N/2; the low bin is always in the low half.
  always_comb begin
    b0_full = bitrev(32'({wr_pair, 1'b0}), AW);
    wr_addr = b0_full[PW-1:0];
  end

  assign unused_b0 = &{1'b0, b0_full[31:PW]};

  // Write FSM: frame start, fill, restart on early start, drop when no bank is free.
  always_comb begin
    wst_d     = wst_q;
    wr_bank_d = wr_bank_q;
    pair_d    = pair_q;
    ovf_d     = ovf_q;
    frm_err_d = frm_err_q;
    wr_en     = 1'b0;
    wr_done   = 1'b0;
    wr_pair   = pair_q;
    case (wst_q)
      W_IDLE: begin
        if (in_valid && in_start) begin
          if (full_q[wr_bank_q]) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_pair = '0;
            pair_d  = PW'(1);
            wst_d   = W_FILL;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_start) begin
            frm_err_d = 1'b1;
            wr_pair   = '0;
            pair_d    = PW'(1);
          end else if (pair_q == LAST_PAIR) begin
            wr_done   = 1'b1;
            wst_d     = W_IDLE;
            wr_bank_d = ~wr_bank_q;
            pair_d    = '0;
          end else begin
            pair_d = pair_q + PW'(1);
          end
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst_q     <= W_IDLE;
      wr_bank_q <= 1'b0;
      pair_q    <= '0;
      ovf_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      wr_bank_q <= wr_bank_d;
      pair_q    <= pair_d;
      ovf_q     <= ovf_d;
      frm_err_q <= frm_err_d;
    end
  end

  fft_reorder_bank #(.N(N), .W(W)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_en && !wr_bank_q),
    .wr_addr (wr_addr),
    .wr_lo   ({in_re0, in_im0}),
    .wr_hi   ({in_re1, in_im1}),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  fft_reorder_bank #(.N(N), .W(W)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_en && wr_bank_q),
    .wr_addr (wr_addr),
    .wr_lo   ({in_re0, in_im0}),
    .wr_hi   ({in_re1, in_im1}),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  // Full flags: set by a completed write, cleared by a completed drain; the two never hit the same bank.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  // Full flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 2'b00;
    else     full_q <= full_d;
  end

  // Read FSM: load the next bin into the output registers on each handshake, hold otherwise.
  always_comb begin
    rst_d       = rst_q;
    rd_bank_d   = rd_bank_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    rd_done     = 1'b0;
    rd_sel      = rd_bank_q;
    load        = 1'b0;
    other_bank  = ~rd_bank_q;
    case (rst_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rst_d = R_DRAIN;
          load  = 1'b1;
          idx_d = '0;
        end
      end
      R_DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == LAST_BIN) begin
            rd_done   = 1'b1;
            rd_bank_d = other_bank;
            idx_d     = '0;
            if (full_q[other_bank]) begin
              rd_sel = other_bank;
              load   = 1'b1;
            end else begin
              rst_d       = R_IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + AW'(1);
            load  = 1'b1;
          end
        end
      end
      default: rst_d = R_IDLE;
    endcase
    rd_addr = idx_d;
    rd_word = rd_sel ? rd_data1 : rd_data0;
    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = (idx_d == LAST_BIN);
      out_re_d    = rd_word[2*W-1:W];
      out_im_d    = rd_word[W-1:0];
    end
  end

  // Read FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q       <= R_IDLE;
      rd_bank_q   <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      rst_q       <= rst_d;
      rd_bank_q   <= rd_bank_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = idx_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign ovf       = ovf_q;
  assign frm_err   = frm_err_q;

endmodule
